inst_mem_responder: RTL and testbench



---
 rtl/inst_mem_responder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_inst_mem_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_responder
//  Purpose  : Responder end of the instruction read bus. Owns the word-
//             organised instruction RAM, serves fetch-unit read requests with
//             a fixed-latency single-cycle valid pulse, and shares the single
//             RAM port with a program-load (UART/debug loader) write port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADR_W     word-address width; RAM depth is 2**ADR_W 32-bit words
//    READ_LAT  cycles from an accepted request to the valid pulse (1..4)
//
//  Ports
//    clk           system clock
//    rst_n         asynchronous active-low reset
//    i_read_req    one-cycle request pulse; address/size sampled with it
//    i_read_w      word access
//    i_read_hw     halfword access (ignored when i_read_w = 1)
//    i_read_adr    32-bit byte address
//    i_read_valid  (out) one-cycle response pulse
//    i_read_data   (out) response data, held until the next valid pulse
//    ld_we         loader write strobe (always has the RAM port)
//    ld_adr        loader word address
//    ld_data       loader write data
//    ld_be         loader byte enables, bit n enables byte n
//    oor_err       (out) sticky out-of-range flag, cleared only by reset
//
//  Note: the read-bus response signals keep the bus-level names
//  i_read_valid / i_read_data even though they are outputs of this block.
// ============================================================================
module inst_mem_responder #(
  parameter int ADR_W    = 12,
  parameter int READ_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_read_req,
  input  logic             i_read_w,
  input  logic             i_read_hw,
  input  logic [31:0]      i_read_adr,
  output logic             i_read_valid,
  output logic [31:0]      i_read_data,
  input  logic             ld_we,
  input  logic [ADR_W-1:0] ld_adr,
  input  logic [31:0]      ld_data,
  input  logic [3:0]       ld_be,
  output logic             oor_err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;   // nothing outstanding
  localparam logic [1:0] S_ISSUE = 2'd1;   // read waiting for the RAM port
  localparam logic [1:0] S_WAIT  = 2'd2;   // read issued, counting latency

  // The counter holds the number of cycles already spent since launch; the
  // response is registered when it reaches READ_LAT-1 so that the valid pulse
  // lands exactly READ_LAT cycles after the launch cycle.
  localparam logic [2:0] C_CNT_LAST = 3'(READ_LAT - 1);
  localparam int         C_DEPTH    = 2 ** ADR_W;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;

  // Latched request attributes
  logic [ADR_W-1:0] r_word;
  logic             r_w;
  logic             r_hw;
  logic [1:0]       r_off;
  logic             r_oor;

  // Attributes of the request being worked on this cycle: the live inputs in
  // a request cycle (latest request wins), otherwise the latched copy.
  logic             w_adr_oor;
  logic [ADR_W-1:0] w_cur_word;
  logic             w_cur_w;
  logic             w_cur_hw;
  logic [1:0]       w_cur_off;
  logic             w_cur_oor;

  logic             w_pending;
  logic             w_launch;
  logic             w_ram_rd;
  logic             w_done;

  logic [31:0]      r_mem [0:C_DEPTH-1];
  logic [31:0]      r_ram_q;
  logic [31:0]      w_src_word;
  logic [31:0]      w_fmt_data;

  logic             r_valid;
  logic [31:0]      r_data;
  logic             r_oor_err;

  // --------------------------------------------------------------------------
  // Out-of-range detection: any byte-address bit above the RAM span set
  // --------------------------------------------------------------------------
  generate
    if (ADR_W + 2 < 32) begin : g_oor_chk
      assign w_adr_oor = |i_read_adr[31:ADR_W+2];
    end else begin : g_oor_none
      assign w_adr_oor = 1'b0;
    end
  endgenerate

  assign w_cur_word = i_read_req ? i_read_adr[ADR_W+1:2] : r_word;
  assign w_cur_w    = i_read_req ? i_read_w              : r_w;
  assign w_cur_hw   = i_read_req ? i_read_hw             : r_hw;
  assign w_cur_off  = i_read_req ? i_read_adr[1:0]       : r_off;
  assign w_cur_oor  = i_read_req ? w_adr_oor             : r_oor;

  // A read is pending whenever a fresh request arrives or one is parked in
  // ISSUE. Out-of-range reads never touch the RAM, so they do not need the
  // port and launch regardless of loader activity.
  assign w_pending = i_read_req | (r_state == S_ISSUE);
  assign w_launch  = w_pending & (~ld_we | w_cur_oor);
  assign w_ram_rd  = w_launch & ~w_cur_oor;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = S_IDLE;
    w_cnt_nxt   = 3'd0;
    if (w_pending) begin
      if (w_launch) begin
        // With single-cycle latency the response is registered in the launch
        // cycle itself, so there is nothing left to wait for.
        if (READ_LAT > 1) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 3'd1;
        end
      end else begin
        w_state_nxt = S_ISSUE;
      end
    end else if ((r_state == S_WAIT) && (r_cnt != C_CNT_LAST)) begin
      w_state_nxt = S_WAIT;
      w_cnt_nxt   = r_cnt + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (response strobe)
  // --------------------------------------------------------------------------
  // A request arriving in the last WAIT cycle suppresses the response of the
  // read it replaces.
  always_comb begin
    w_done = 1'b0;
    if (w_launch && (READ_LAT == 1)) begin
      w_done = 1'b1;
    end else if (!i_read_req && (r_state == S_WAIT) && (r_cnt == C_CNT_LAST)) begin
      w_done = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Request attribute latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_w    <= 1'b0;
      r_hw   <= 1'b0;
      r_off  <= 2'd0;
      r_oor  <= 1'b0;
    end else if (i_read_req) begin
      r_word <= i_read_adr[ADR_W+1:2];
      r_w    <= i_read_w;
      r_hw   <= i_read_hw;
      r_off  <= i_read_adr[1:0];
      r_oor  <= w_adr_oor;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction RAM: single port, loader write has priority. The read and
  // the write are mutually exclusive by construction of w_ram_rd.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ld_be[b]) begin
          r_mem[ld_adr][8*b +: 8] <= ld_data[8*b +: 8];
        end
      end
    end
    if (w_ram_rd) begin
      r_ram_q <= r_mem[w_cur_word];
    end
  end

  // With single-cycle latency the RAM word has to be formatted in the launch
  // cycle, so it is taken straight from the array; otherwise the registered
  // read snapshot taken at launch is used.
  generate
    if (READ_LAT == 1) begin : g_lat_one
      assign w_src_word = r_mem[w_cur_word];
    end else begin : g_lat_multi
      assign w_src_word = r_ram_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Response formatting (zero-extended sub-word extraction)
  // --------------------------------------------------------------------------
  always_comb begin
    w_fmt_data = 32'h0;
    if (w_cur_oor) begin
      w_fmt_data = 32'h0;
    end else if (w_cur_w) begin
      w_fmt_data = w_src_word;
    end else if (w_cur_hw) begin
      w_fmt_data = {16'h0, (w_cur_off[1] ? w_src_word[31:16] : w_src_word[15:0])};
    end else begin
      case (w_cur_off)
        2'd0:    w_fmt_data = {24'h0, w_src_word[7:0]};
        2'd1:    w_fmt_data = {24'h0, w_src_word[15:8]};
        2'd2:    w_fmt_data = {24'h0, w_src_word[23:16]};
        default: w_fmt_data = {24'h0, w_src_word[31:24]};
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Response registers: data and the sticky error only move on a valid pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= 32'h0;
      r_oor_err <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data <= w_fmt_data;
        if (w_cur_oor) begin
          r_oor_err <= 1'b1;
        end
      end
    end
  end

  assign i_read_valid = r_valid;
  assign i_read_data  = r_data;
  assign oor_err      = r_oor_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_mem_responder
//  Purpose  : Self-checking bench for inst_mem_responder: directed scenarios
//             plus randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_responder;

  localparam int ADR_W = 12;
  localparam int LAT   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_read_req = 1'b0;
  logic             i_read_w = 1'b0;
  logic             i_read_hw = 1'b0;
  logic [31:0]      i_read_adr = 32'h0;
  logic             i_read_valid;
  logic [31:0]      i_read_data;
  logic             ld_we = 1'b0;
  logic [ADR_W-1:0] ld_adr = '0;
  logic [31:0]      ld_data = 32'h0;
  logic [3:0]       ld_be = 4'h0;
  logic             oor_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  inst_mem_responder #(.ADR_W(ADR_W), .READ_LAT(LAT)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read_req   (i_read_req),
    .i_read_w     (i_read_w),
    .i_read_hw    (i_read_hw),
    .i_read_adr   (i_read_adr),
    .i_read_valid (i_read_valid),
    .i_read_data  (i_read_data),
    .ld_we        (ld_we),
    .ld_adr       (ld_adr),
    .ld_data      (ld_data),
    .ld_be        (ld_be),
    .oor_err      (oor_err)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    i_read_req = 1'b0;
    i_read_w   = 1'b0;
    i_read_hw  = 1'b0;
    ld_we      = 1'b0;
    ld_be      = 4'h0;
  endtask

  task automatic do_write(input int adr, input logic [31:0] data, input logic [3:0] be);
    ld_we   = 1'b1;
    ld_adr  = ADR_W'(adr);
    ld_data = data;
    ld_be   = be;
    step();
    ld_we   = 1'b0;
  endtask

  // Issues one read and reports the observed latency (-1 on timeout) and data.
  task automatic do_read(input logic [31:0] adr, input bit w, input bit hw,
                         output int lat, output logic [31:0] data);
    i_read_req = 1'b1;
    i_read_adr = adr;
    i_read_w   = w;
    i_read_hw  = hw;
    step();
    i_read_req = 1'b0;
    lat  = -1;
    data = 32'hx;
    for (int k = 1; k <= 12; k++) begin
      if (i_read_valid === 1'b1) begin
        lat  = k;
        data = i_read_data;
        break;
      end
      step();
    end
    step();
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] word, input bit w, input bit hw,
                                      input logic [1:0] off);
    int sh;
    if (w) return word;
    if (hw) begin
      sh = off[1] ? 16 : 0;
      return (word >> sh) & 32'h0000_FFFF;
    end
    sh = 8 * int'(off);
    return (word >> sh) & 32'h0000_00FF;
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (i_read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", i_read_valid); end
    checks++; if (i_read_data !== 32'h0) begin errors++; $display("FAIL reset_data got %08h want 00000000", i_read_data); end
    checks++; if (oor_err !== 1'b0) begin errors++; $display("FAIL reset_oor got %0b want 0", oor_err); end
    rst_n = 1'b1;
    step();
    step();
    checks++; if (i_read_valid !== 1'b0) begin errors++; $display("FAIL reset_rel_valid got %0b want 0", i_read_valid); end
  endtask

  task automatic test_basic();
    do_write(4, 32'h0000_0013, 4'hF);
    i_read_req = 1'b1; i_read_w = 1'b1; i_read_hw = 1'b0; i_read_adr = 32'h10;
    step();
    i_read_req = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      checks++; if (i_read_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid cycle N+%0d got %0b want 0", k, i_read_valid); end
      step();
    end
    checks++; if (i_read_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", i_read_valid); end
    checks++; if (i_read_data !== 32'h0000_0013) begin errors++; $display("FAIL basic_data got %08h want 00000013", i_read_data); end
    step();
    checks++; if (i_read_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %0b want 0", i_read_valid); end
    step();
    step();
    checks++; if (i_read_data !== 32'h0000_0013) begin errors++; $display("FAIL basic_hold got %08h want 00000013", i_read_data); end
  endtask

  task automatic test_format();
    logic [31:0] f_adr [7] = '{32'h2, 32'h1, 32'h3, 32'h0, 32'h3, 32'h1, 32'h2};
    bit          f_w   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit          f_hw  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] f_exp [7] = '{32'h0000_8765, 32'h0000_0043, 32'h8765_4321, 32'h0000_4321,
                               32'h0000_0087, 32'h0000_4321, 32'h0000_0065};
    int          lat;
    logic [31:0] data;
    do_write(0, 32'h8765_4321, 4'hF);
    for (int i = 0; i < 7; i++) begin
      do_read(f_adr[i], f_w[i], f_hw[i], lat, data);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL format_lat[%0d] got %0d want %0d", i, lat, LAT); end
      checks++; if (data !== f_exp[i]) begin errors++; $display("FAIL format_data[%0d] got %08h want %08h", i, data, f_exp[i]); end
    end
  endtask

  task automatic test_byte_enable();
    int          lat;
    logic [31:0] data;
    do_write(5, 32'hAABB_CCDD, 4'hF);
    do_write(5, 32'h1122_3344, 4'b0101);
    do_read(32'h14, 1'b1, 1'b0, lat, data);
    checks++; if (data !== 32'hAA22_CC44) begin errors++; $display("FAIL be_data got %08h want AA22CC44", data); end
  endtask

  task automatic test_conflict();
    int          seen = -1;
    int          pulses = 0;
    logic [31:0] data = 32'h0;
    i_read_req = 1'b1; i_read_w = 1'b1; i_read_hw = 1'b0; i_read_adr = 32'h1C;
    ld_we = 1'b1; ld_adr = ADR_W'(7); ld_data = 32'hDEAD_BEEF; ld_be = 4'hF;
    step();
    i_read_req = 1'b0;
    ld_data = 32'hCAFE_F00D;
    if (i_read_valid === 1'b1) pulses++;
    step();
    ld_we = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      if (i_read_valid === 1'b1) begin
        pulses++;
        if (seen < 0) begin seen = k; data = i_read_data; end
      end
      step();
    end
    checks++; if (seen !== 2 + LAT) begin errors++; $display("FAIL conflict_lat got %0d want %0d", seen, 2 + LAT); end
    checks++; if (data !== 32'hCAFE_F00D) begin errors++; $display("FAIL conflict_data got %08h want CAFEF00D", data); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL conflict_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int          seen = -1;
    int          pulses = 0;
    logic [31:0] data = 32'h0;
    do_write(8, 32'h0A0A_0A0A, 4'hF);
    do_write(9, 32'h0B0B_0B0B, 4'hF);
    i_read_req = 1'b1; i_read_w = 1'b1; i_read_hw = 1'b0; i_read_adr = 32'h20;
    step();
    i_read_adr = 32'h24;
    for (int k = 1; k <= 12; k++) begin
      if (i_read_valid === 1'b1) begin
        pulses++;
        if (seen < 0) begin seen = k; data = i_read_data; end
      end
      step();
      i_read_req = 1'b0;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    checks++; if (seen !== 1 + LAT) begin errors++; $display("FAIL b2b_lat got %0d want %0d", seen, 1 + LAT); end
    checks++; if (data !== 32'h0B0B_0B0B) begin errors++; $display("FAIL b2b_data got %08h want 0B0B0B0B", data); end
  endtask

  task automatic test_reset_mid();
    int          pulses = 0;
    int          lat;
    logic [31:0] data;
    do_write(10, 32'h5A5A_5A5A, 4'hF);
    i_read_req = 1'b1; i_read_w = 1'b1; i_read_hw = 1'b0; i_read_adr = 32'h28;
    step();
    i_read_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (i_read_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got %08h want 00000000", i_read_data); end
    step();
    checks++; if (i_read_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", i_read_valid); end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (i_read_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_stale_pulses got %0d want 0", pulses); end
    checks++; if (i_read_data !== 32'h0) begin errors++; $display("FAIL rstmid_data_after got %08h want 00000000", i_read_data); end
    do_read(32'h28, 1'b1, 1'b0, lat, data);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL rstmid_next_lat got %0d want %0d", lat, LAT); end
    checks++; if (data !== 32'h5A5A_5A5A) begin errors++; $display("FAIL rstmid_next_data got %08h want 5A5A5A5A", data); end
  endtask

  task automatic test_oor();
    int          lat;
    logic [31:0] data;
    checks++; if (oor_err !== 1'b0) begin errors++; $display("FAIL oor_pre got %0b want 0", oor_err); end
    do_read(32'h0001_0000, 1'b1, 1'b0, lat, data);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL oor_lat got %0d want %0d", lat, LAT); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL oor_data got %08h want 00000000", data); end
    checks++; if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_flag got %0b want 1", oor_err); end
    do_read(32'h28, 1'b1, 1'b0, lat, data);
    checks++; if (data !== 32'h5A5A_5A5A) begin errors++; $display("FAIL oor_next_data got %08h want 5A5A5A5A", data); end
    step();
    step();
    checks++; if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_sticky got %0b want 1", oor_err); end
  endtask

  // Randomized traffic. The model tracks the single pending read as "accepted,
  // launched at cycle L, due at L+LAT" and applies the formatting rules to a
  // mirror of the low 16 RAM words.
  task automatic test_random();
    logic [31:0] mdl [16];
    bit          pend = 1'b0, launched = 1'b0, p_w = 1'b0, p_hw = 1'b0, p_oor = 1'b0;
    logic [1:0]  p_off = 2'd0;
    int          p_word = 0, due = 0;
    logic [31:0] snap = 32'h0, hold = 32'h0;
    bit          exp_oor = 1'b0;
    bit          ev, req, oor, we;
    logic [31:0] adr, wdata;
    logic [3:0]  wbe;
    int          wadr;

    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      do_write(i, mdl[i], 4'hF);
    end

    for (int i = 0; i < 410; i++) begin
      ev = pend && launched && (due == cyc);
      if (ev) begin
        pend = 1'b0;
        hold = snap;
        if (p_oor) exp_oor = 1'b1;
      end
      checks++; if (i_read_valid !== ev) begin errors++; $display("FAIL rand_valid cyc %0d got %0b want %0b", cyc, i_read_valid, ev); end
      checks++; if (i_read_data !== hold) begin errors++; $display("FAIL rand_data cyc %0d got %08h want %08h", cyc, i_read_data, hold); end
      checks++; if (oor_err !== exp_oor) begin errors++; $display("FAIL rand_oor cyc %0d got %0b want %0b", cyc, oor_err, exp_oor); end

      req = (i < 400) && ($urandom_range(0, 99) < 35);
      oor = req && ($urandom_range(0, 99) < 8);
      if (oor) adr = (32'($urandom_range(1, 32'h3FFFF)) << 14) | ($urandom & 32'h3FFF);
      else     adr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      we    = (i < 400) && !oor && ($urandom_range(0, 99) < 30);
      wadr  = int'($urandom_range(0, 15));
      wdata = $urandom;
      wbe   = 4'($urandom_range(0, 15));

      i_read_req = req;
      i_read_adr = adr;
      i_read_w   = 1'($urandom_range(0, 1));
      i_read_hw  = 1'($urandom_range(0, 1));
      ld_we      = we;
      ld_adr     = ADR_W'(wadr);
      ld_data    = wdata;
      ld_be      = wbe;

      if (req) begin
        pend     = 1'b1;
        launched = 1'b0;
        p_word   = int'((adr >> 2) & 32'hF);
        p_off    = adr[1:0];
        p_w      = i_read_w;
        p_hw     = i_read_hw;
        p_oor    = (adr >> (ADR_W + 2)) != 32'h0;
      end
      if (pend && !launched && !we) begin
        launched = 1'b1;
        due      = cyc + LAT;
        snap     = p_oor ? 32'h0 : fmt(mdl[p_word], p_w, p_hw, p_off);
      end
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wbe[b]) mdl[wadr][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      step();
    end
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_format();
    test_byte_enable();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    test_oor();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
